// File: rtl/sigma_tile_pkg.sv
// Shared memory-bus widths and arbitration helpers for the sigma tile.
package sigma_tile_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = 4;

    localparam int RR_MAX_N   = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, scanning upward modulo n (n <= RR_MAX_N).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                         input int unsigned         ptr,
                                         input int unsigned         n);
        rr_pick_t   res;
        logic [2:0] k;
        res = '0;
        for (int unsigned i = 0; i < RR_MAX_N; i++) begin
            if (i < n) begin
                k = 3'((ptr + i) % n);
                if (!res.found && req[k]) begin
                    res.found = 1'b1;
                    res.idx   = k;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of issuing-master IDs for outstanding reads.
module id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot, so a push while full is still safe.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_arb_rr.sv
// N-master round-robin arbiter onto one split request/response memory port,
// with in-order routing of multiple outstanding read responses.
module mem_arb_rr
    import sigma_tile_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic [NUM_MASTERS-1:0]                  m_req_i,
    input  logic [NUM_MASTERS-1:0]                  m_we_i,
    input  logic [NUM_MASTERS-1:0][MEM_ADDR_W-1:0]  m_addr_i,
    input  logic [NUM_MASTERS-1:0][MEM_BE_W-1:0]    m_be_i,
    input  logic [NUM_MASTERS-1:0][MEM_DATA_W-1:0]  m_wdata_i,
    output logic [NUM_MASTERS-1:0]                  m_ack_o,
    output logic [NUM_MASTERS-1:0]                  m_resp_o,
    output logic [NUM_MASTERS-1:0][MEM_DATA_W-1:0]  m_rdata_o,
    output logic                                    s_req_o,
    output logic                                    s_we_o,
    output logic [MEM_ADDR_W-1:0]                   s_addr_o,
    output logic [MEM_BE_W-1:0]                     s_be_o,
    output logic [MEM_DATA_W-1:0]                   s_wdata_o,
    input  logic                                    s_ack_i,
    input  logic                                    s_resp_i,
    input  logic [MEM_DATA_W-1:0]                   s_rdata_i,
    output logic                                    err_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    head_id;
    logic [RR_MAX_N-1:0] req_ext;
    rr_pick_t            pick;
    logic                issue;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_MASTERS-1:0] = m_req_i;
        pick                     = rr_pick(req_ext, 32'(rr_ptr), NUM_MASTERS);
        winner                   = IDX_W'(pick.idx);
    end

    // Reset gates the combinational paths so outputs drop as soon as rst_n_i falls.
    assign issue  = rst_n_i & pick.found & ~fifo_full;
    assign accept = issue & s_ack_i;
    assign push   = accept & ~s_we_o;
    assign pop    = s_resp_i & ~fifo_empty;

    always_comb begin
        s_req_o   = issue;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_ack_o   = '0;
        if (issue) begin
            s_we_o          = m_we_i[winner];
            s_addr_o        = m_addr_i[winner];
            s_be_o          = m_be_i[winner];
            s_wdata_o       = m_wdata_i[winner];
            m_ack_o[winner] = s_ack_i;
        end
    end

    always_comb begin
        m_resp_o  = '0;
        m_rdata_o = '0;
        if (rst_n_i && !fifo_empty) begin
            m_resp_o[head_id]  = s_resp_i;
            m_rdata_o[head_id] = s_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
            end
            if (s_resp_i && fifo_empty) err_o <= 1'b1;
        end
    end

    id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push      (push),
        .push_data (winner),
        .pop       (pop),
        .head      (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_count_bounded: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        fifo_count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed bench for mem_arb_rr: vector table plus hand-written corner sequences.
module tb_mem_arb_rr;

    localparam int NM = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i;
    logic [NM-1:0]        m_req_i;
    logic [NM-1:0]        m_we_i;
    logic [NM-1:0][31:0]  m_addr_i;
    logic [NM-1:0][3:0]   m_be_i;
    logic [NM-1:0][31:0]  m_wdata_i;
    logic [NM-1:0]        m_ack_o;
    logic [NM-1:0]        m_resp_o;
    logic [NM-1:0][31:0]  m_rdata_o;
    logic                 s_req_o;
    logic                 s_we_o;
    logic [31:0]          s_addr_o;
    logic [3:0]           s_be_o;
    logic [31:0]          s_wdata_o;
    logic                 s_ack_i;
    logic                 s_resp_i;
    logic [31:0]          s_rdata_i;
    logic                 err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_arb_rr #(
        .NUM_MASTERS     (NM),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .m_req_i   (m_req_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_be_i    (m_be_i),
        .m_wdata_i (m_wdata_i),
        .m_ack_o   (m_ack_o),
        .m_resp_o  (m_resp_o),
        .m_rdata_o (m_rdata_o),
        .s_req_o   (s_req_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_be_o    (s_be_o),
        .s_wdata_o (s_wdata_o),
        .s_ack_i   (s_ack_i),
        .s_resp_i  (s_resp_i),
        .s_rdata_i (s_rdata_i),
        .err_o     (err_o)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic        ack;
        logic        resp;
        logic [31:0] rdata;
        logic        e_sreq;
        logic [31:0] e_saddr;
        logic [3:0]  e_mack;
        logic [3:0]  e_mresp;
        logic [1:0]  e_ptr;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] we,
                                input logic ack, input logic resp, input logic [31:0] rd,
                                input logic sreq, input logic [31:0] sa,
                                input logic [3:0] mack, input logic [3:0] mresp,
                                input logic [1:0] ptr);
        vec_t v;
        v.req = req; v.we = we; v.ack = ack; v.resp = resp; v.rdata = rd;
        v.e_sreq = sreq; v.e_saddr = sa; v.e_mack = mack; v.e_mresp = mresp; v.e_ptr = ptr;
        return v;
    endfunction

    function automatic logic [127:0] rd_vec(input logic [3:0] m, input logic [31:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < NM; i++) if (m[i]) r[i*32 +: 32] = d;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] we, input logic ack,
                         input logic resp, input logic [31:0] rd);
        m_req_i   = req;
        m_we_i    = we;
        s_ack_i   = ack;
        s_resp_i  = resp;
        s_rdata_i = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_i = 1'b0;
        for (int i = 0; i < NM; i++) begin
            m_addr_i[i]  = 32'h100 * i;
            m_be_i[i]    = 4'hF;
            m_wdata_i[i] = 32'hD0 + i;
        end
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0);

        // Stall on master 1, write by master 3 to re-home the pointer, then full rotation.
        vecs[0]  = mk(4'b0110, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 4'b0000, 4'b0000, 2'd0);
        vecs[1]  = mk(4'b0110, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 4'b0000, 4'b0000, 2'd0);
        vecs[2]  = mk(4'b0110, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 4'b0000, 4'b0000, 2'd0);
        vecs[3]  = mk(4'b0110, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 4'b0010, 4'b0000, 2'd2);
        vecs[4]  = mk(4'b0110, 4'b0000, 1'b1, 1'b1, 32'h11111111, 1'b1, 32'h200, 4'b0100, 4'b0010, 2'd3);
        vecs[5]  = mk(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h22222222, 1'b0, 32'h000, 4'b0000, 4'b0100, 2'd3);
        vecs[6]  = mk(4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0,        1'b1, 32'h300, 4'b1000, 4'b0000, 2'd0);
        vecs[7]  = mk(4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b1, 32'h000, 4'b0001, 4'b0000, 2'd1);
        vecs[8]  = mk(4'b1111, 4'b0000, 1'b1, 1'b1, 32'h33333333, 1'b1, 32'h100, 4'b0010, 4'b0001, 2'd2);
        vecs[9]  = mk(4'b1111, 4'b0000, 1'b1, 1'b1, 32'h3333AAAA, 1'b1, 32'h200, 4'b0100, 4'b0010, 2'd3);
        vecs[10] = mk(4'b1111, 4'b0000, 1'b1, 1'b1, 32'h3333BBBB, 1'b1, 32'h300, 4'b1000, 4'b0100, 2'd0);
        vecs[11] = mk(4'b1111, 4'b0000, 1'b1, 1'b1, 32'h3333CCCC, 1'b1, 32'h000, 4'b0001, 4'b1000, 2'd1);
        vecs[12] = mk(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h99999999, 1'b0, 32'h000, 4'b0000, 4'b0001, 2'd1);

        #12;
        chk("reset s_req", s_req_o, 1'b0);
        chk("reset m_ack", m_ack_o, 4'b0000);
        chk("reset m_resp", m_resp_o, 4'b0000);
        chk("reset s_addr", s_addr_o, 32'h0);
        chk("reset err", err_o, 1'b0);
        chk("reset count", dut.fifo_count, 3'd0);
        chk("reset rr_ptr", dut.rr_ptr, 2'd0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].ack, vecs[i].resp, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d s_req", i), s_req_o, vecs[i].e_sreq);
            chk($sformatf("v%0d s_addr", i), s_addr_o, vecs[i].e_saddr);
            chk($sformatf("v%0d m_ack", i), m_ack_o, vecs[i].e_mack);
            chk($sformatf("v%0d m_resp", i), m_resp_o, vecs[i].e_mresp);
            chk($sformatf("v%0d m_rdata", i), m_rdata_o, rd_vec(vecs[i].e_mresp, vecs[i].rdata));
            tick();
            chk($sformatf("v%0d rr_ptr", i), dut.rr_ptr, vecs[i].e_ptr);
        end
        chk("table drained count", dut.fifo_count, 3'd0);

        // Routing: master 3 then master 0 read; responses return in issue order.
        m_addr_i[3] = 32'h40;
        m_addr_i[0] = 32'h80;
        drive(4'b1000, 4'b0000, 1'b1, 1'b0, 32'h0);
        #1;
        chk("route issue3 addr", s_addr_o, 32'h40);
        chk("route issue3 ack", m_ack_o, 4'b1000);
        tick();
        drive(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        #1;
        chk("route issue0 addr", s_addr_o, 32'h80);
        chk("route issue0 ack", m_ack_o, 4'b0001);
        tick();
        chk("route count", dut.fifo_count, 3'd2);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'hDEADBEEF);
        #1;
        chk("route resp1", m_resp_o, 4'b1000);
        chk("route rdata1", m_rdata_o, rd_vec(4'b1000, 32'hDEADBEEF));
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        #1;
        chk("route idle resp", m_resp_o, 4'b0000);
        tick();
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'hCAFEF00D);
        #1;
        chk("route resp2", m_resp_o, 4'b0001);
        chk("route rdata2", m_rdata_o, rd_vec(4'b0001, 32'hCAFEF00D));
        tick();
        chk("route end count", dut.fifo_count, 3'd0);
        m_addr_i[3] = 32'h300;
        m_addr_i[0] = 32'h000;

        // Full FIFO: four reads from rr_ptr=1 leave IDs 1,2,3,0 outstanding.
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("full count", dut.fifo_count, 3'd4);
        m_wdata_i[2] = 32'hA5A5A5A5;
        drive(4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0);
        #1;
        chk("full s_req", s_req_o, 1'b0);
        chk("full m_ack", m_ack_o, 4'b0000);
        tick();
        chk("full held count", dut.fifo_count, 3'd4);
        drive(4'b0100, 4'b0100, 1'b1, 1'b1, 32'h44444444);
        #1;
        chk("full resp head", m_resp_o, 4'b0010);
        chk("full resp rdata", m_rdata_o, rd_vec(4'b0010, 32'h44444444));
        chk("full pop s_req", s_req_o, 1'b0);
        chk("full pop m_ack", m_ack_o, 4'b0000);
        tick();
        chk("full after pop count", dut.fifo_count, 3'd3);
        drive(4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0);
        #1;
        chk("write s_req", s_req_o, 1'b1);
        chk("write s_we", s_we_o, 1'b1);
        chk("write s_addr", s_addr_o, 32'h200);
        chk("write s_wdata", s_wdata_o, 32'hA5A5A5A5);
        chk("write m_ack", m_ack_o, 4'b0100);
        tick();
        chk("write no push count", dut.fifo_count, 3'd3);

        // Simultaneous push and pop at count 2.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0);
        #1;
        chk("drain resp", m_resp_o, 4'b0100);
        tick();
        chk("pp start count", dut.fifo_count, 3'd2);
        drive(4'b0010, 4'b0000, 1'b1, 1'b1, 32'h55555555);
        #1;
        chk("pp ack", m_ack_o, 4'b0010);
        chk("pp resp", m_resp_o, 4'b1000);
        tick();
        chk("pp count", dut.fifo_count, 3'd2);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h66666666);
        #1;
        chk("pp head advanced", m_resp_o, 4'b0001);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h77777777);
        #1;
        chk("pp tail id", m_resp_o, 4'b0010);
        chk("pp tail rdata", m_rdata_o, rd_vec(4'b0010, 32'h77777777));
        tick();
        chk("pp end count", dut.fifo_count, 3'd0);

        // Spurious response, sticky error, then asynchronous reset mid-cycle.
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h12345678);
        #1;
        chk("spur m_resp", m_resp_o, 4'b0000);
        chk("spur err before edge", err_o, 1'b0);
        tick();
        chk("spur err set", err_o, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("spur err sticky", err_o, 1'b1);
        drive(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        #1;
        chk("pre-reset s_req", s_req_o, 1'b1);
        tick();
        chk("pre-reset count", dut.fifo_count, 3'd1);
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async rst err", err_o, 1'b0);
        chk("async rst s_req", s_req_o, 1'b0);
        chk("async rst m_ack", m_ack_o, 4'b0000);
        chk("async rst count", dut.fifo_count, 3'd0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h87654321);
        #1;
        chk("post-rst m_resp", m_resp_o, 4'b0000);
        tick();
        chk("post-rst err", err_o, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arb_rr.md
Name: mem_arb_rr

Overview:
- N-master to 1-slave round-robin arbiter for MemSplit32-style split request/response buses inside the sigma tile.
- Multiplexes requests from the cores' instruction/data ports onto one shared memory port.
- Supports multiple outstanding reads: an in-order ID FIFO routes each read response to its issuing master.
- Intended to replace the single-outstanding two-master L1 arbiter where pipelined memory is used.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 4, depth of the read-ID FIFO (power of 2, 2..16).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- m_req_i  in  NUM_MASTERS  per-master request valid.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS x 32  per-master address.
- m_be_i  in  NUM_MASTERS x 4  per-master byte enables.
- m_wdata_i  in  NUM_MASTERS x 32  per-master write data.
- m_ack_o  out  NUM_MASTERS  per-master request accepted.
- m_resp_o  out  NUM_MASTERS  per-master read response valid.
- m_rdata_o  out  NUM_MASTERS x 32  per-master read data.
- s_req_o  out  1  slave request valid.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  32  slave address.
- s_be_o  out  4  slave byte enables.
- s_wdata_o  out  32  slave write data.
- s_ack_i  in  1  slave accepted the request.
- s_resp_i  in  1  slave read response valid; responses return in issue order.
- s_rdata_i  in  32  slave read data.
- err_o  out  1  sticky: response arrived with no outstanding read.

Behaviour:
- Reset (rst_n_i low, asynchronous): rr_ptr=0, FIFO empty (count=0, rd/wr pointers=0), err_o=0.
- Reset outputs: s_req_o=0, m_ack_o=0, m_resp_o=0, all data/addr outputs 0.
- Grant is combinational.
  - Winner = first requesting master at or after rr_ptr, scanning upward modulo NUM_MASTERS.
  - No requester: s_* outputs are all 0.
- Slave outputs carry the winner's request fields. Only the winner sees m_ack_o = s_ack_i; all other acks are 0.
- Accept = s_req_o & s_ack_i.
  - On accept, rr_ptr <= (winner+1) mod NUM_MASTERS.
  - With no accept, rr_ptr holds, including when the slave stalls.
- Read accept (accept & !we) pushes the winner ID into the FIFO. Write accepts push nothing and produce no response.
- FIFO full: issue is blocked. s_req_o=0 and all m_ack_o=0 while count==MAX_OUTSTANDING, whether the pending request is a read or a write. This keeps ordering simple.
- Response routing is combinational from the FIFO head.
  - m_resp_o[head]=s_resp_i and m_rdata_o[head]=s_rdata_i. All other masters get resp=0 and rdata=0.
  - A response pops the FIFO.
- Same-cycle push and pop: count is unchanged and both pointers advance. This is legal when full (pop frees the slot). Issue remains blocked that cycle because the full check uses registered count.
- Response with an empty FIFO: dropped (no m_resp_o), err_o <= 1 and stays set until reset.
- Latency: request path 0 cycles; response path 0 cycles. Back-to-back accepts every cycle are allowed.
- Pointer wrap: natural wrap for power-of-2 depth. count width is $clog2(MAX_OUTSTANDING)+1.
- Reset mid-operation: all outstanding IDs are discarded. Responses arriving afterwards raise err_o.

Decomposition:
- Shared package sigma_tile_pkg gets:
  - MEM_ADDR_W=32, MEM_DATA_W=32, MEM_BE_W=4;
  - the function rr_pick (masked priority scan returning index and a found flag).
- One sub-module: id_fifo.
  - Synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports push/push_data/pop/head/full/empty/count.
  - Same async active-low reset.
- mem_arb_rr holds rr_ptr, the grant mux, response demux and err_o.

Test Plan:
- Fairness, NUM_MASTERS=4, all m_req_i=4'b1111, s_ack_i=1, reads to addr 0x100*i -> grant order 0,1,2,3,0; one m_ack_o per cycle; s_addr_o = 0x000, 0x100, 0x200, 0x300, 0x000.
- Slave stall: m_req_i=4'b0110, s_ack_i=0 for 3 cycles then 1 -> master 1 held on s_* for all 4 cycles; rr_ptr stays 0 until the accept, then becomes 2; next grant is master 2.
- Routing: master 3 reads 0x40 and master 0 reads 0x80; slave returns 0xDEADBEEF then 0xCAFEF00D, 2 and 5 cycles later -> m_resp_o[3] with 0xDEADBEEF first, then m_resp_o[0] with 0xCAFEF00D; no other m_resp_o asserted.
- Full FIFO, MAX_OUTSTANDING=4: 4 accepted reads with no response; master 2 requests a write -> s_req_o=0 and m_ack_o=0.
  - Next cycle s_resp_i=1 -> the head master gets the response and count becomes 3.
  - The following cycle the write is issued and acked with no FIFO push.
- Simultaneous push/pop: at count=2, a read accept and s_resp_i in the same cycle -> count stays 2; the head advances; the new ID is at the tail.
- Spurious response / reset: s_resp_i=1 with the FIFO empty -> no m_resp_o, err_o=1 and sticky.
  - Then rst_n_i low mid-cycle -> err_o, m_ack_o and s_req_o go 0 immediately (asynchronously).
